// File: rtl/conv_encoder_k4.sv
// conv_encoder_k4: rate-1/2 K=4 convolutional encoder framed in N-bit blocks
// define TAIL_FLUSH_EN to append 3 zero tail bits so each frame ends in state 0
module conv_encoder_k4 #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_sym,
  output logic [2:0] out_state,
  output logic       out_last
);
  localparam int CW = $clog2(N) + 1;
  typedef enum logic {DATA, TAIL} state_t;
  state_t         st_q;
  logic [2:0]     s_q;
  logic [CW-1:0]  cnt_q;
  logic           out_valid_q;
  logic           out_last_q;
  logic [1:0]     out_sym_q;
  logic [2:0]     out_state_q;
  logic           free;
  logic           take;
  logic           b;
  logic           g0;
  logic           g1;
  logic           last_bit;
  logic [2:0]     s_d;
  assign free     = !out_valid_q || out_ready;
  assign in_ready = !rst && st_q == DATA && free;
  // tail cycles encode an internal zero and advance whenever the output slot is free
  assign b        = st_q == DATA && in_bit;
  assign take     = st_q == DATA ? in_valid && in_ready : free;
  assign g0       = b ^ s_q[2] ^ s_q[1] ^ s_q[0];
  assign g1       = b ^ s_q[2] ^ s_q[0];
  assign s_d      = {b, s_q[2:1]};
  assign last_bit = cnt_q == (st_q == DATA ? CW'(N - 1) : CW'(2));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= DATA;
      s_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sym_q   <= '0;
      out_state_q <= '0;
    end else if (take) begin
      out_valid_q <= 1'b1;
      out_sym_q   <= {g0, g1};
      out_state_q <= s_d;
      s_q         <= s_d;
      cnt_q       <= last_bit ? '0 : cnt_q + 1'b1;
`ifdef TAIL_FLUSH_EN
      out_last_q  <= last_bit && st_q == TAIL;
      if (last_bit) st_q <= st_q == DATA ? TAIL : DATA;
`else
      out_last_q  <= last_bit;
      if (last_bit) s_q <= '0;
`endif
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
  assign out_valid = out_valid_q;
  assign out_sym   = out_sym_q;
  assign out_state = out_state_q;
  assign out_last  = out_last_q;
endmodule

// File: tb/tb_conv_encoder_k4.sv
// tb_conv_encoder_k4: directed and model-checked stimulus for conv_encoder_k4
module tb_conv_encoder_k4;
  localparam int N = 8;
  logic       clk = 0;
  logic       rst = 1;
  logic       in_valid = 0;
  logic       in_bit = 0;
  logic       out_ready = 1;
  logic       in_ready;
  logic       out_valid;
  logic       out_last;
  logic [1:0] out_sym;
  logic [2:0] out_state;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         rand_rdy = 0;
  bit         rdy_force = 1;
  logic [5:0] got[$];
  bit         sent[$];
  int         d_sym[8]   = '{3, 3, 1, 3, 1, 1, 3, 0};
  int         d_state[8] = '{4, 2, 5, 6, 3, 1, 0, 0};
  int         d_bits[8]  = '{1, 0, 1, 1, 0, 0, 0, 0};
  int         t_sym[11]   = '{3, 0, 2, 1, 1, 1, 1, 1, 2, 1, 3};
  int         t_state[11] = '{4, 6, 7, 7, 7, 7, 7, 7, 3, 1, 0};
  logic [1:0] h_sym;
  logic [2:0] h_state;

  conv_encoder_k4 #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
    .out_state(out_state), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) sent.push_back(in_bit);
      if (out_valid && out_ready) got.push_back({out_last, out_state, out_sym});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit b, input int idle);
    int k;
    in_valid = 0;
    repeat (idle) tick;
    in_valid = 1;
    in_bit = b;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      k++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 0, 1);
    tick;
    in_valid = 0;
  endtask

  task automatic wait_got(input int n);
    int k;
    k = 0;
    while (got.size() < n && k < 500) begin
      tick;
      k++;
    end
    repeat (3) tick;
    check("drain_count", got.size(), n);
  endtask

  task automatic compare_model(input string tag);
    logic [5:0] exp_q[$];
    logic [2:0] s;
    logic       b, g0, g1;
    int         c;
    s = 0;
    c = 0;
    foreach (sent[i]) begin
      b  = sent[i];
      g0 = b ^ s[2] ^ s[1] ^ s[0];
      g1 = b ^ s[2] ^ s[0];
      s  = {b, s[2:1]};
      c++;
`ifdef TAIL_FLUSH_EN
      exp_q.push_back({1'b0, s, g0, g1});
      if (c == N) begin
        c = 0;
        for (int t = 0; t < 3; t++) begin
          g0 = s[2] ^ s[1] ^ s[0];
          g1 = s[2] ^ s[0];
          s  = {1'b0, s[2:1]};
          exp_q.push_back({t == 2, s, g0, g1});
        end
      end
`else
      exp_q.push_back({c == N, s, g0, g1});
      if (c == N) begin
        c = 0;
        s = 0;
      end
`endif
    end
    wait_got(exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
  endtask

  task automatic clear_q;
    got.delete();
    sent.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sym", out_sym, 0);
    check("rst_out_state", out_state, 0);
    check("rst_out_last", out_last, 0);
    @(negedge clk) rst = 0;
    @(negedge clk) check("rel_in_ready", in_ready, 1);
    tick;
`ifdef TAIL_FLUSH_EN
    for (int i = 0; i < N; i++) send(1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("tail_in_ready[%0d]", i), in_ready, 0);
    end
    @(negedge clk) check("post_tail_in_ready", in_ready, 1);
    tick;
    wait_got(11);
    for (int i = 0; i < 11 && i < got.size(); i++) begin
      check($sformatf("tail_sym[%0d]", i), got[i][1:0], t_sym[i]);
      check($sformatf("tail_state[%0d]", i), got[i][4:2], t_state[i]);
      check($sformatf("tail_last[%0d]", i), got[i][5], i == 10);
    end
`else
    for (int i = 0; i < N; i++) send(d_bits[i][0], 0);
    @(negedge clk) check("no_gap_in_ready", in_ready, 1);
    tick;
    wait_got(8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      check($sformatf("dir_sym[%0d]", i), got[i][1:0], d_sym[i]);
      check($sformatf("dir_state[%0d]", i), got[i][4:2], d_state[i]);
      check($sformatf("dir_last[%0d]", i), got[i][5], i == 7);
    end
`endif
    clear_q();
    send(1, 0);
    send(1, 0);
    send(0, 0);
    in_valid = 1;
    in_bit = 1;
    rdy_force = 0;
    @(negedge clk);
    h_sym = out_sym;
    h_state = out_state;
    check("bp_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_sym[%0d]", i), out_sym, h_sym);
      check($sformatf("bp_state[%0d]", i), out_state, h_state);
      check($sformatf("bp_in_ready[%0d]", i), in_ready, 0);
    end
    tick;
    rdy_force = 1;
    send(1, 0);
    send(0, 0);
    send(1, 0);
    send(0, 0);
    send(1, 0);
    compare_model("bp");
    clear_q();
    rand_rdy = 1;
    for (int i = 0; i < 3 * N; i++) send(1'($urandom_range(0, 1)), $urandom_range(0, 2));
    compare_model("rnd");
    rand_rdy = 0;
    repeat (2) tick;
    clear_q();
    send(1, 0);
    send(1, 0);
    send(0, 0);
    send(1, 0);
    in_valid = 1;
    in_bit = 1;
    @(negedge clk);
    #2;
    rst = 1;
    in_valid = 0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_sym", out_sym, 0);
    check("mid_rst_out_state", out_state, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(negedge clk) rst = 0;
    @(negedge clk) check("mid_rel_in_ready", in_ready, 1);
    tick;
    clear_q();
    for (int i = 0; i < N; i++) send(d_bits[i][0], 0);
    compare_model("post_rst");
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      check($sformatf("post_rst_sym[%0d]", i), got[i][1:0], d_sym[i]);
      check($sformatf("post_rst_state[%0d]", i), got[i][4:2], d_state[i]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
